// File: rtl/nic_vc_scheduler_pkg.sv
// Shared constants and types for the NIC virtual-channel scheduler.
// VC bit index = vnet * N_OF_VC + vc_within_vnet.
package nic_vc_scheduler_pkg;

  localparam int N_OF_VC = 2;
  localparam int N_OF_VN = 3;
  localparam int NUM_VC  = N_OF_VC * N_OF_VN;

  typedef enum logic [1:0] {
    VC_IDLE = 2'd0,
    VC_BUSY = 2'd1,
    VC_WAIT = 2'd2
  } vc_state_e;

  // Virtual network that a flat VC index belongs to.
  function automatic int vc_vnet(input int vc);
    return vc / N_OF_VC;
  endfunction

endpackage

// File: rtl/nic_vc_scheduler_if.sv
// Request/grant bundle between the injection FIFOs and the VC scheduler.
interface nic_vc_scheduler_if
  import nic_vc_scheduler_pkg::*;
#(
  parameter int N_OF_REQUEST   = 3,
  parameter int N_BITS_VNET_ID = 2,
  parameter int N_BITS_VC_ID   = NUM_VC
) ();

  logic [N_OF_REQUEST-1:0]                r_va_i;
  logic [N_OF_REQUEST*N_BITS_VNET_ID-1:0] vnet_of_the_request_i;
  logic [N_OF_REQUEST-1:0]                release_i;
  logic [NUM_VC-1:0]                      free_signal_i;
  logic [N_OF_REQUEST-1:0]                g_va_o;
  logic [N_OF_REQUEST*N_BITS_VC_ID-1:0]   g_vc_id_o;
  logic [NUM_VC-1:0]                      vc_busy_o;

  modport master (
    output r_va_i, vnet_of_the_request_i, release_i, free_signal_i,
    input  g_va_o, g_vc_id_o, vc_busy_o
  );

  modport slave (
    input  r_va_i, vnet_of_the_request_i, release_i, free_signal_i,
    output g_va_o, g_vc_id_o, vc_busy_o
  );

endinterface

// File: rtl/nic_vc_state_fsm.sv
// Per-VC ownership state: IDLE -> BUSY on grant, BUSY -> WAIT on the owner's
// tail flit, WAIT -> IDLE once the router buffer reports empty.
module nic_vc_state_fsm
  import nic_vc_scheduler_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_grant,
  input  logic      i_release,
  input  logic      i_free,
  output vc_state_e o_state
);

  vc_state_e r_state;
  vc_state_e w_next;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
    if (rst) r_state <= VC_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    // NOTE: default assigned first so no branch leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      VC_IDLE: if (i_grant)   w_next = VC_BUSY;
      VC_BUSY: if (i_release) w_next = VC_WAIT;
      VC_WAIT: if (i_free)    w_next = VC_IDLE;
      default:                w_next = VC_IDLE;
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/nic_vc_scheduler.sv
// Round-robin VC scheduler: registered grants, persistent per-VC ownership,
// VC reuse only after the router reports the buffer empty.
module nic_vc_scheduler
  import nic_vc_scheduler_pkg::*;
#(
  parameter int N_OF_REQUEST   = 3,
  parameter int N_BITS_VNET_ID = 2,
  parameter int N_BITS_VC_ID   = NUM_VC
) (
  input logic               clk,
  input logic               rst,
  nic_vc_scheduler_if.slave bus
);

  localparam int PTR_W = (N_OF_REQUEST > 1) ? $clog2(N_OF_REQUEST) : 1;
  typedef logic [PTR_W-1:0] ptr_t;

  logic [N_OF_REQUEST-1:0][N_BITS_VNET_ID-1:0] w_vnet;
  logic [N_OF_REQUEST-1:0][N_BITS_VC_ID-1:0]   r_g_vc_id;
  logic [N_OF_REQUEST-1:0][N_BITS_VC_ID-1:0]   w_grant_vc;
  logic [N_OF_REQUEST-1:0]                     r_g_va;
  logic [N_OF_REQUEST-1:0]                     w_grant;
  logic [N_OF_REQUEST-1:0]                     w_elig;
  logic [NUM_VC-1:0]                           w_alloc;
  logic [NUM_VC-1:0]                           w_taken;
  logic [NUM_VC-1:0]                           w_vc_grant;
  logic [NUM_VC-1:0]                           w_vc_release;
  logic [NUM_VC-1:0]                           w_vc_busy;
  logic [NUM_VC-1:0]                           r_vc_busy;
  ptr_t                                        r_rr_ptr;
  ptr_t                                        w_next_ptr;
  ptr_t                                        w_scan_idx;
  logic                                        w_found;
  int                                          w_scan;
  vc_state_e                                   w_vc_state [NUM_VC];

  assign w_vnet = bus.vnet_of_the_request_i;

  for (genvar j = 0; j < NUM_VC; j++) begin : g_vc
    nic_vc_state_fsm u_fsm (
      .clk       (clk),
      .rst       (rst),
      .i_grant   (w_vc_grant[j]),
      .i_release (w_vc_release[j]),
      .i_free    (bus.free_signal_i[j]),
      .o_state   (w_vc_state[j])
    );
    assign w_alloc[j]   = (w_vc_state[j] == VC_IDLE) && bus.free_signal_i[j];
    assign w_vc_busy[j] = (w_vc_state[j] != VC_IDLE);
  end

  // A requester that still owns a VC is ineligible, so a same-cycle release
  // only makes its new request eligible on the following cycle.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_OF_REQUEST; i++) begin
      w_elig[i] = bus.r_va_i[i] && (r_g_vc_id[i] == '0) &&
                  (int'(w_vnet[i]) < N_OF_VN);
    end
  end

  // Scan from rr_ptr; each eligible requester takes the lowest free VC of its vnet.
  always_comb begin
    w_grant    = '0;
    w_grant_vc = '0;
    w_taken    = '0;
    w_next_ptr = r_rr_ptr;
    w_scan     = 0;
    w_scan_idx = '0;
    w_found    = 1'b0;
    for (int k = 0; k < N_OF_REQUEST; k++) begin
      w_scan = int'(r_rr_ptr) + k;
      if (w_scan >= N_OF_REQUEST) w_scan = w_scan - N_OF_REQUEST;
      w_scan_idx = ptr_t'(w_scan);
      w_found    = 1'b0;
      if (w_elig[w_scan_idx]) begin
        for (int j = 0; j < NUM_VC; j++) begin
          if (!w_found && w_alloc[j] && !w_taken[j] &&
              (vc_vnet(j) == int'(w_vnet[w_scan_idx]))) begin
            w_found                    = 1'b1;
            w_taken[j]                 = 1'b1;
            w_grant[w_scan_idx]        = 1'b1;
            w_grant_vc[w_scan_idx][j]  = 1'b1;
            w_next_ptr = (w_scan == N_OF_REQUEST - 1) ? '0 : ptr_t'(w_scan + 1);
          end
        end
      end
    end
  end

  // Owner slices are one-hot or zero, so a release from a non-owner contributes nothing.
  always_comb begin
    w_vc_grant   = '0;
    w_vc_release = '0;
    for (int i = 0; i < N_OF_REQUEST; i++) begin
      w_vc_grant   = w_vc_grant | w_grant_vc[i];
      w_vc_release = w_vc_release | (r_g_vc_id[i] & {N_BITS_VC_ID{bus.release_i[i]}});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_g_va    <= '0;
      r_g_vc_id <= '0;
      r_vc_busy <= '0;
    end else begin
      r_g_va    <= w_grant;
      r_vc_busy <= w_vc_busy;
      if (w_grant != '0) r_rr_ptr <= w_next_ptr;
      for (int i = 0; i < N_OF_REQUEST; i++) begin
        if (w_grant[i])            r_g_vc_id[i] <= w_grant_vc[i];
        else if (bus.release_i[i]) r_g_vc_id[i] <= '0;
      end
    end
  end

  assign bus.g_va_o    = r_g_va;
  assign bus.g_vc_id_o = r_g_vc_id;
  assign bus.vc_busy_o = r_vc_busy;

endmodule

// File: tb/tb_nic_vc_scheduler.sv
// Directed bench for nic_vc_scheduler: 2 VCs x 3 vnets, 3 requesters.
module tb_nic_vc_scheduler;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  nic_vc_scheduler_if #(.N_OF_REQUEST(3), .N_BITS_VNET_ID(2), .N_BITS_VC_ID(6)) bus ();

  nic_vc_scheduler #(.N_OF_REQUEST(3), .N_BITS_VNET_ID(2), .N_BITS_VC_ID(6)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] va, input logic [1:0] v0,
                         input logic [1:0] v1, input logic [1:0] v2);
    bus.r_va_i                = va;
    bus.vnet_of_the_request_i = {v2, v1, v0};
  endtask

  task automatic clear_inputs();
    set_req(3'b000, 2'd0, 2'd0, 2'd0);
    bus.release_i     = 3'b000;
    bus.free_signal_i = 6'b111111;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    n_checks++;
    if (bus.g_va_o !== 3'b000) begin
      n_errors++; $display("FAIL reset_g_va: got %b expected %b", bus.g_va_o, 3'b000);
    end
    n_checks++;
    if (bus.g_vc_id_o !== 18'h0) begin
      n_errors++; $display("FAIL reset_g_vc_id: got %h expected %h", bus.g_vc_id_o, 18'h0);
    end
    n_checks++;
    if (bus.vc_busy_o !== 6'b000000) begin
      n_errors++; $display("FAIL reset_vc_busy: got %b expected %b", bus.vc_busy_o, 6'b000000);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_grant();
    do_reset();
    set_req(3'b001, 2'd1, 2'd0, 2'd0);
    tick();
    n_checks++;
    if (bus.g_va_o !== 3'b001) begin
      n_errors++; $display("FAIL single_g_va: got %b expected %b", bus.g_va_o, 3'b001);
    end
    n_checks++;
    if (bus.g_vc_id_o[5:0] !== 6'b000100) begin
      n_errors++; $display("FAIL single_vc_id: got %b expected %b", bus.g_vc_id_o[5:0], 6'b000100);
    end
    n_checks++;
    if (bus.vc_busy_o !== 6'b000000) begin
      n_errors++; $display("FAIL single_busy_early: got %b expected %b", bus.vc_busy_o, 6'b000000);
    end
    // Request still held: the owner flag must suppress a second grant.
    tick();
    n_checks++;
    if (bus.g_va_o !== 3'b000) begin
      n_errors++; $display("FAIL single_no_regrant: got %b expected %b", bus.g_va_o, 3'b000);
    end
    n_checks++;
    if (bus.vc_busy_o !== 6'b000100) begin
      n_errors++; $display("FAIL single_busy: got %b expected %b", bus.vc_busy_o, 6'b000100);
    end
    n_checks++;
    if (bus.g_vc_id_o[5:0] !== 6'b000100) begin
      n_errors++; $display("FAIL single_vc_hold: got %b expected %b", bus.g_vc_id_o[5:0], 6'b000100);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_req(3'b111, 2'd0, 2'd0, 2'd0);
    tick();
    n_checks++;
    if (bus.g_va_o !== 3'b011) begin
      n_errors++; $display("FAIL rr_first_g_va: got %b expected %b", bus.g_va_o, 3'b011);
    end
    n_checks++;
    if (bus.g_vc_id_o !== {6'b000000, 6'b000010, 6'b000001}) begin
      n_errors++; $display("FAIL rr_first_vc_id: got %h expected %h", bus.g_vc_id_o,
                           {6'b000000, 6'b000010, 6'b000001});
    end
    set_req(3'b100, 2'd0, 2'd0, 2'd0);
    bus.release_i = 3'b001;
    tick();
    n_checks++;
    if (bus.g_vc_id_o[5:0] !== 6'b000000) begin
      n_errors++; $display("FAIL rr_release_slice0: got %b expected %b", bus.g_vc_id_o[5:0], 6'b000000);
    end
    bus.release_i = 3'b000;
    set_req(3'b101, 2'd0, 2'd0, 2'd0);
    tick();
    n_checks++;
    if (bus.g_va_o !== 3'b000) begin
      n_errors++; $display("FAIL rr_wait_no_grant: got %b expected %b", bus.g_va_o, 3'b000);
    end
    tick();
    n_checks++;
    if (bus.g_va_o !== 3'b100) begin
      n_errors++; $display("FAIL rr_req2_wins: got %b expected %b", bus.g_va_o, 3'b100);
    end
    n_checks++;
    if (bus.g_vc_id_o[17:12] !== 6'b000001) begin
      n_errors++; $display("FAIL rr_req2_vc: got %b expected %b", bus.g_vc_id_o[17:12], 6'b000001);
    end
    n_checks++;
    if (bus.g_vc_id_o[5:0] !== 6'b000000) begin
      n_errors++; $display("FAIL rr_req0_none: got %b expected %b", bus.g_vc_id_o[5:0], 6'b000000);
    end
  endtask

  task automatic test_release_wait();
    do_reset();
    set_req(3'b001, 2'd0, 2'd0, 2'd0);
    tick();
    n_checks++;
    if (bus.g_vc_id_o[5:0] !== 6'b000001) begin
      n_errors++; $display("FAIL rw_grant: got %b expected %b", bus.g_vc_id_o[5:0], 6'b000001);
    end
    set_req(3'b000, 2'd0, 2'd0, 2'd0);
    bus.free_signal_i = 6'b111100;
    bus.release_i     = 3'b001;
    tick();
    bus.release_i = 3'b000;
    n_checks++;
    if (bus.g_vc_id_o[5:0] !== 6'b000000) begin
      n_errors++; $display("FAIL rw_slice_cleared: got %b expected %b", bus.g_vc_id_o[5:0], 6'b000000);
    end
    set_req(3'b001, 2'd0, 2'd0, 2'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (bus.vc_busy_o !== 6'b000001 || bus.g_va_o !== 3'b000) begin
        n_errors++; $display("FAIL rw_hold_wait[%0d]: busy %b g_va %b expected busy %b g_va %b",
                             c, bus.vc_busy_o, bus.g_va_o, 6'b000001, 3'b000);
      end
    end
    bus.free_signal_i = 6'b111101;
    tick();
    n_checks++;
    if (bus.g_va_o !== 3'b000) begin
      n_errors++; $display("FAIL rw_not_yet: got %b expected %b", bus.g_va_o, 3'b000);
    end
    tick();
    n_checks++;
    if (bus.g_va_o !== 3'b001 || bus.g_vc_id_o[5:0] !== 6'b000001) begin
      n_errors++; $display("FAIL rw_regrant: g_va %b vc %b expected g_va %b vc %b",
                           bus.g_va_o, bus.g_vc_id_o[5:0], 3'b001, 6'b000001);
    end
  endtask

  task automatic test_same_cycle_release();
    do_reset();
    set_req(3'b010, 2'd0, 2'd2, 2'd0);
    tick();
    n_checks++;
    if (bus.g_vc_id_o[11:6] !== 6'b010000) begin
      n_errors++; $display("FAIL sc_grant: got %b expected %b", bus.g_vc_id_o[11:6], 6'b010000);
    end
    bus.free_signal_i = 6'b011111;
    bus.release_i     = 3'b010;
    tick();
    bus.release_i = 3'b000;
    n_checks++;
    if (bus.g_va_o !== 3'b000 || bus.g_vc_id_o[11:6] !== 6'b000000) begin
      n_errors++; $display("FAIL sc_release: g_va %b vc %b expected g_va %b vc %b",
                           bus.g_va_o, bus.g_vc_id_o[11:6], 3'b000, 6'b000000);
    end
    tick();
    n_checks++;
    if (bus.g_va_o !== 3'b000) begin
      n_errors++; $display("FAIL sc_wait_to_idle: got %b expected %b", bus.g_va_o, 3'b000);
    end
    tick();
    n_checks++;
    if (bus.g_va_o !== 3'b010 || bus.g_vc_id_o[11:6] !== 6'b010000) begin
      n_errors++; $display("FAIL sc_regrant: g_va %b vc %b expected g_va %b vc %b",
                           bus.g_va_o, bus.g_vc_id_o[11:6], 3'b010, 6'b010000);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    set_req(3'b100, 2'd0, 2'd0, 2'd3);
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (bus.g_va_o !== 3'b000 || bus.vc_busy_o !== 6'b000000) begin
        n_errors++; $display("FAIL oor_vnet3[%0d]: g_va %b busy %b expected g_va %b busy %b",
                             c, bus.g_va_o, bus.vc_busy_o, 3'b000, 6'b000000);
      end
    end
    set_req(3'b001, 2'd0, 2'd0, 2'd0);
    tick();
    set_req(3'b000, 2'd0, 2'd0, 2'd0);
    bus.release_i = 3'b110;
    tick();
    bus.release_i = 3'b000;
    tick();
    n_checks++;
    if (bus.g_vc_id_o !== 18'h00001) begin
      n_errors++; $display("FAIL stray_release_vc: got %h expected %h", bus.g_vc_id_o, 18'h00001);
    end
    n_checks++;
    if (bus.vc_busy_o !== 6'b000001) begin
      n_errors++; $display("FAIL stray_release_busy: got %b expected %b", bus.vc_busy_o, 6'b000001);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_req(3'b011, 2'd0, 2'd1, 2'd0);
    tick();
    n_checks++;
    if (bus.g_va_o !== 3'b011) begin
      n_errors++; $display("FAIL mr_grant01: got %b expected %b", bus.g_va_o, 3'b011);
    end
    set_req(3'b100, 2'd0, 2'd1, 2'd2);
    tick();
    n_checks++;
    if (bus.g_va_o !== 3'b100 || bus.g_vc_id_o[17:12] !== 6'b010000) begin
      n_errors++; $display("FAIL mr_grant2: g_va %b vc %b expected g_va %b vc %b",
                           bus.g_va_o, bus.g_vc_id_o[17:12], 3'b100, 6'b010000);
    end
    set_req(3'b000, 2'd0, 2'd1, 2'd2);
    bus.free_signal_i = 6'b101111;
    bus.release_i     = 3'b100;
    tick();
    bus.release_i = 3'b000;
    tick();
    n_checks++;
    if (bus.vc_busy_o !== 6'b010101) begin
      n_errors++; $display("FAIL mr_pre_busy: got %b expected %b", bus.vc_busy_o, 6'b010101);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.g_va_o !== 3'b000 || bus.g_vc_id_o !== 18'h0 || bus.vc_busy_o !== 6'b000000) begin
      n_errors++; $display("FAIL mr_reset: g_va %b vc %h busy %b expected all zero",
                           bus.g_va_o, bus.g_vc_id_o, bus.vc_busy_o);
    end
    rst = 1'b0;
    clear_inputs();
    set_req(3'b001, 2'd1, 2'd0, 2'd0);
    tick();
    n_checks++;
    if (bus.g_va_o !== 3'b001 || bus.g_vc_id_o[5:0] !== 6'b000100) begin
      n_errors++; $display("FAIL mr_fresh: g_va %b vc %b expected g_va %b vc %b",
                           bus.g_va_o, bus.g_vc_id_o[5:0], 3'b001, 6'b000100);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_single_grant();
    test_round_robin();
    test_release_wait();
    test_same_cycle_release();
    test_out_of_range();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
